// File: rtl/par2ser_pkg.sv
// Shared types and constants for the par2ser transmitter.
//   par2ser_state_t : engine state (IDLE, SHIFT, GAP)
//   MAX_IDLE_GAP    : largest supported inter-word gap
//   GAP_CNT_W       : width of the gap counter
//   bit_cnt_w()     : width of the bit counter for a given word length
package par2ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } par2ser_state_t;

  localparam int unsigned MAX_IDLE_GAP = 15;
  localparam int unsigned GAP_CNT_W    = 4;

  // Bit counter width; never narrower than one bit.
  function automatic int unsigned bit_cnt_w(input int unsigned bitlen);
    return (bitlen < 2) ? 1 : int'($clog2(bitlen));
  endfunction

endpackage

// File: rtl/par2ser_if.sv
// Parallel-in / serial-out bus of the par2ser transmitter.
//   ParDataIn/ParDataValid/ParDataReady : word handshake (source -> transmitter)
//   SerDataOut/SerDataEn                : serial link, LSB first
//   WordDone                            : pulse on the last bit of a word
//   Busy                                : engine active or word held
// master = word source / link observer, slave = transmitter.
interface par2ser_if #(
  parameter int unsigned bitlen = 8
);

  logic [bitlen-1:0] ParDataIn;
  logic              ParDataValid;
  logic              ParDataReady;
  logic              SerDataOut;
  logic              SerDataEn;
  logic              WordDone;
  logic              Busy;

  modport master (
    output ParDataIn, ParDataValid,
    input  ParDataReady, SerDataOut, SerDataEn, WordDone, Busy
  );

  modport slave (
    input  ParDataIn, ParDataValid,
    output ParDataReady, SerDataOut, SerDataEn, WordDone, Busy
  );

endinterface

// File: rtl/par2ser_hold.sv
// One-entry valid/ready holding buffer.
//   Clk, Rst   : clock, synchronous active-high reset
//   in_data    : incoming word
//   in_valid   : incoming word valid
//   in_ready   : buffer empty (registered, no path from in_valid)
//   take       : consumer removes the held word (only while hold_full)
//   hold_data  : held word
//   hold_full  : buffer occupied
module par2ser_hold #(
  parameter int unsigned bitlen = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [bitlen-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              take,
  output logic [bitlen-1:0] hold_data,
  output logic              hold_full
);

  // take only happens while full and accept only while empty, so they never collide.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hold_data <= '0;
      hold_full <= 1'b0;
      in_ready  <= 1'b1;
    end else if (take) begin
      hold_full <= 1'b0;
      in_ready  <= 1'b1;
    end else if (in_valid && in_ready) begin
      hold_data <= in_data;
      hold_full <= 1'b1;
      in_ready  <= 1'b0;
    end
  end

endmodule

// File: rtl/par2ser.sv
// Parallel-to-serial transmitter: takes a word through a one-entry holding
// buffer and shifts it out LSB first, one bit per clock, with an optional
// forced idle gap between words.
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : par2ser_if slave (word handshake in, serial link out)
module par2ser
  import par2ser_pkg::*;
#(
  parameter int unsigned bitlen  = 8,
  parameter int unsigned IdleGap = 0
) (
  input  logic     Clk,
  input  logic     Rst,
  par2ser_if.slave bus
);

  localparam int unsigned CNT_W      = bit_cnt_w(bitlen);
  localparam int unsigned GAP_CYCLES = (IdleGap > MAX_IDLE_GAP) ? MAX_IDLE_GAP : IdleGap;
  localparam logic [CNT_W-1:0]     LAST_BIT   = CNT_W'(bitlen - 1);
  localparam logic [CNT_W-1:0]     PENULT_BIT = CNT_W'(bitlen - 2);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST   = GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  par2ser_state_t    state, state_nxt;
  logic [bitlen-1:0] shift_reg, shift_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [GAP_CNT_W-1:0] gap_cnt, gap_cnt_nxt;
  logic ser_out, ser_out_nxt;
  logic ser_en, ser_en_nxt;
  logic word_done, word_done_nxt;
  logic busy, busy_nxt;

  logic [bitlen-1:0] hold_data;
  logic hold_full, hold_ready, take, load, accept, hold_full_nxt;

  par2ser_hold #(.bitlen(bitlen)) u_hold (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_data   (bus.ParDataIn),
    .in_valid  (bus.ParDataValid),
    .in_ready  (hold_ready),
    .take      (take),
    .hold_data (hold_data),
    .hold_full (hold_full)
  );

  assign accept = bus.ParDataValid && hold_ready;

  // Next state and next (registered) outputs; ser_out shows the bit indexed by bit_cnt.
  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift_reg;
    bit_cnt_nxt   = bit_cnt;
    gap_cnt_nxt   = gap_cnt;
    ser_out_nxt   = 1'b0;
    ser_en_nxt    = 1'b0;
    word_done_nxt = 1'b0;
    take          = 1'b0;
    load          = 1'b0;

    unique case (state)
      IDLE: load = hold_full;
      SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          if (GAP_CYCLES == 0) begin
            load = hold_full;
            if (!hold_full) state_nxt = IDLE;
          end else begin
            state_nxt   = GAP;
            gap_cnt_nxt = '0;
          end
        end else begin
          shift_nxt     = shift_reg >> 1;
          ser_out_nxt   = shift_reg[0];
          ser_en_nxt    = 1'b1;
          bit_cnt_nxt   = bit_cnt + 1'b1;
          word_done_nxt = (bit_cnt == PENULT_BIT);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          load = hold_full;
          if (!hold_full) state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Bit 0 goes straight to the output; the remaining bits wait in shift_reg.
    if (load) begin
      take        = 1'b1;
      shift_nxt   = hold_data >> 1;
      ser_out_nxt = hold_data[0];
      ser_en_nxt  = 1'b1;
      bit_cnt_nxt = '0;
      state_nxt   = SHIFT;
    end

    hold_full_nxt = take ? 1'b0 : (accept ? 1'b1 : hold_full);
    busy_nxt      = (state_nxt != IDLE) || hold_full_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ser_out   <= 1'b0;
      ser_en    <= 1'b0;
      word_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      ser_out   <= ser_out_nxt;
      ser_en    <= ser_en_nxt;
      word_done <= word_done_nxt;
      busy      <= busy_nxt;
    end
  end

  assign bus.ParDataReady = hold_ready;
  assign bus.SerDataOut   = ser_out;
  assign bus.SerDataEn    = ser_en;
  assign bus.WordDone     = word_done;
  assign bus.Busy         = busy;

endmodule

// File: tb/tb_par2ser.sv
// Self-checking bench for par2ser: one instance with IdleGap=0 and one with
// IdleGap=2, a cycle-level interval model of the expected serial stream, and a
// loopback receiver that reassembles words from SerDataOut/SerDataEn.
module tb_par2ser;

  localparam int L = 8;

  typedef struct {
    logic [L-1:0] w;
    int           a;
  } pend_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vld = 1'b0;
  logic         sel = 1'b0;
  logic [L-1:0] din = '0;

  always #5 clk = ~clk;

  par2ser_if #(.bitlen(L)) if0 ();
  par2ser_if #(.bitlen(L)) if2 ();

  assign if0.ParDataIn    = din;
  assign if0.ParDataValid = vld & ~sel;
  assign if2.ParDataIn    = din;
  assign if2.ParDataValid = vld & sel;

  par2ser #(.bitlen(L), .IdleGap(0)) dut0 (.Clk(clk), .Rst(rst), .bus(if0));
  par2ser #(.bitlen(L), .IdleGap(2)) dut2 (.Clk(clk), .Rst(rst), .bus(if2));

  logic en_o, out_o, wd_o, rdy_o, busy_o;
  assign en_o   = sel ? if2.SerDataEn    : if0.SerDataEn;
  assign out_o  = sel ? if2.SerDataOut   : if0.SerDataOut;
  assign wd_o   = sel ? if2.WordDone     : if0.WordDone;
  assign rdy_o  = sel ? if2.ParDataReady : if0.ParDataReady;
  assign busy_o = sel ? if2.Busy         : if0.Busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit last_acc = 1'b0;

  // Interval model: words wait in pend, the active word occupies [cur_s, cur_s+L-1].
  pend_t        pend[$];
  logic [L-1:0] cur_w = '0;
  bit           cur_v = 1'b0;
  int           cur_s = 0;
  int           last_end = -100;
  int           gap = 0;
  logic [L-1:0] exp_done[$];

  // Loopback receiver and link statistics.
  logic [L-1:0] rx_words[$];
  logic [L-1:0] rx_sh = '0;
  int rx_n = 0;
  int run_len = 0, max_run = 0, zero_run = 0, gap_before = 0;
  int wd_last = 0, wd_prev = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    bit acc, r;
    logic [L-1:0] d;
    pend_t p;
    int s;
    logic e_en, e_out, e_wd, e_rdy, e_busy;
    acc = (vld === 1'b1) && (rdy_o === 1'b1) && (rst === 1'b0);
    r   = rst;
    d   = din;
    @(posedge clk);
    #1;
    cyc++;
    last_acc = acc;
    if (cur_v && cyc > cur_s + L - 1) begin
      last_end = cur_s + L - 1;
      exp_done.push_back(cur_w);
      cur_v = 1'b0;
    end
    if (r) begin
      pend.delete();
      cur_v    = 1'b0;
      last_end = -100;
      rx_n     = 0;
    end else if (acc) begin
      p.w = d;
      p.a = cyc;
      pend.push_back(p);
    end
    if (!cur_v && pend.size() > 0) begin
      s = pend[0].a + 1;
      if (last_end + gap + 1 > s) s = last_end + gap + 1;
      if (cyc >= s) begin
        cur_w = pend[0].w;
        cur_s = cyc;
        cur_v = 1'b1;
        void'(pend.pop_front());
      end
    end
    e_en   = cur_v;
    e_out  = cur_v ? cur_w[cyc - cur_s] : 1'b0;
    e_wd   = cur_v && (cyc == cur_s + L - 1);
    e_rdy  = (pend.size() == 0);
    e_busy = (pend.size() != 0) || cur_v || (cyc <= last_end + gap);
    chk("SerDataEn",    32'(en_o),   32'(e_en));
    chk("SerDataOut",   32'(out_o),  32'(e_out));
    chk("WordDone",     32'(wd_o),   32'(e_wd));
    chk("ParDataReady", 32'(rdy_o),  32'(e_rdy));
    chk("Busy",         32'(busy_o), 32'(e_busy));
    if (en_o === 1'b1) begin
      rx_sh[rx_n] = out_o;
      rx_n++;
      if (rx_n == L) begin
        rx_words.push_back(rx_sh);
        rx_n = 0;
      end
      if (run_len == 0) gap_before = zero_run;
      run_len++;
      zero_run = 0;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
      zero_run++;
    end
    if (wd_o === 1'b1) begin
      wd_prev = wd_last;
      wd_last = cyc;
    end
  endtask

  task automatic send(input logic [L-1:0] w);
    int n = 0;
    vld = 1'b1;
    din = w;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 100);
    chk("send_accept", 32'(last_acc), 32'd1);
    vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    vld = 1'b0;
    do begin
      tick();
      n++;
    end while ((busy_o !== 1'b0) && n < 200);
    tick();
    chk("drain_idle", 32'(busy_o), 32'd0);
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_count"}, 32'(rx_words.size()), 32'(exp_done.size()));
    for (int i = 0; i < rx_words.size() && i < exp_done.size(); i++)
      chk({tag, "_word"}, 32'(rx_words[i]), 32'(exp_done[i]));
    rx_words.delete();
    exp_done.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nrx, n;

    // Reset held two cycles with Valid high: nothing accepted.
    rst = 1'b1; vld = 1'b1; din = 8'h55;
    tick(); tick();
    chk("rst_en",    32'(en_o),   32'd0);
    chk("rst_out",   32'(out_o),  32'd0);
    chk("rst_wd",    32'(wd_o),   32'd0);
    chk("rst_ready", 32'(rdy_o),  32'd1);
    chk("rst_busy",  32'(busy_o), 32'd0);
    rst = 1'b0; vld = 1'b0;
    tick();
    chk("rst_no_accept_busy", 32'(busy_o), 32'd0);

    // Single word, bit 0 one cycle after the accept edge.
    tick();
    max_run = 0;
    send(8'h2b);
    n = cyc;
    tick();
    chk("single_first_time", 32'(cyc - n), 32'd1);
    chk("single_first_en",   32'(en_o),    32'd1);
    chk("single_first_bit",  32'(out_o),   32'd1);
    drain();
    chk("single_word", 32'(rx_words[$]), 32'h2b);
    chk("single_run",  32'(max_run),     32'd8);
    chk("single_en_after", 32'(en_o),    32'd0);

    // Back-to-back pair with no gap.
    max_run = 0;
    send(8'h2b);
    send(8'ha5);
    drain();
    chk("b2b_run",     32'(max_run),         32'd16);
    chk("b2b_wd_gap",  32'(wd_last - wd_prev), 32'd8);
    chk("b2b_first",   32'(rx_words[$-1]),   32'h2b);
    chk("b2b_second",  32'(rx_words[$]),     32'ha5);

    // Valid kept high across three words.
    send(8'h01);
    send(8'h80);
    chk("held_ready_low", 32'(rdy_o), 32'd0);
    send(8'hff);
    drain();
    chk("loop_w0", 32'(rx_words[$-2]), 32'h01);
    chk("loop_w1", 32'(rx_words[$-1]), 32'h80);
    chk("loop_w2", 32'(rx_words[$]),   32'hff);

    // Reset after the third bit discards both the active and the held word.
    nrx = rx_words.size();
    send(8'ha5);
    send(8'h77);
    n = 0;
    while (rx_n != 3 && n < 50) begin
      tick();
      n++;
    end
    chk("mid_reached_bit3", 32'(rx_n), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_en",    32'(en_o),   32'd0);
    chk("mid_rst_ready", 32'(rdy_o),  32'd1);
    chk("mid_rst_busy",  32'(busy_o), 32'd0);
    send(8'h3c);
    drain();
    chk("mid_count", 32'(rx_words.size()), 32'(nrx + 1));
    chk("mid_word",  32'(rx_words[$]),     32'h3c);
    compare_all("directed");

    // Random traffic, no gap.
    for (int i = 0; i < 300; i++) begin
      vld = ($urandom_range(0, 99) < 60);
      din = L'($urandom);
      tick();
    end
    drain();
    compare_all("rand_g0");

    // Switch to the IdleGap=2 instance.
    sel = 1'b1; gap = 2; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    max_run = 0;
    send(8'h2b);
    send(8'ha5);
    drain();
    chk("g2_gap",    32'(gap_before),        32'd2);
    chk("g2_run",    32'(max_run),           32'd8);
    chk("g2_wd_gap", 32'(wd_last - wd_prev), 32'd10);
    compare_all("g2_pair");

    for (int i = 0; i < 300; i++) begin
      vld = ($urandom_range(0, 99) < 40);
      din = L'($urandom);
      tick();
    end
    drain();
    compare_all("rand_g2");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/par2ser.md
Name: par2ser

Overview:
- Parallel-to-serial transmitter; the transmit counterpart of ser2par.
- Accepts a bitlen-wide word through a valid/ready handshake and shifts it out LSB first, one bit per Clk.
- Drives a SerDataOut/SerDataEn pair that connects directly to ser2par SerDataIn/SerDataEn.
- A one-entry holding register allows back-to-back words with no gap.

Parameters:
- bitlen, 8, word width in bits; legal range 2..32.
- IdleGap, 0, number of cycles with SerDataEn=0 forced between consecutive words; legal range 0..15.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Rst  input  1  synchronous reset, active-high.
- ParDataIn  input  bitlen  word to transmit; bit 0 is sent first.
- ParDataValid  input  1  ParDataIn is valid.
- ParDataReady  output  1  holding register is empty; a word is accepted on an edge where Valid=1 and Ready=1.
- SerDataOut  output  1  serial data bit; 0 whenever SerDataEn=0.
- SerDataEn  output  1  qualifies SerDataOut; high for exactly bitlen cycles per word.
- WordDone  output  1  one-cycle pulse coincident with the last bit of each word.
- Busy  output  1  high when state is not IDLE or the holding register is full.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high on Rst.
- Reset: on a Clk edge with Rst=1, all outputs and state are cleared.
  - After reset: SerDataOut=0, SerDataEn=0, WordDone=0, Busy=0, ParDataReady=1, state IDLE.
  - Holding register and shift register are emptied; BitCnt=0.
  - Rst has priority over ParDataValid.
- Holding register:
  - ParDataReady = !HoldFull. It is decoded from a register and has no combinational path from ParDataValid.
  - On accept: HoldReg <= ParDataIn, HoldFull <= 1.
  - A transfer into the shift register clears HoldFull.
  - Accept and transfer can never occur on the same edge, because Ready=0 while HoldFull=1.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if HoldFull, load ShiftReg from HoldReg, set BitCnt=0, drive SerDataEn=1 and SerDataOut=HoldReg[0] from the next cycle, and go to SHIFT. Otherwise stay in IDLE with SerDataEn=0.
  - SHIFT: each edge shifts ShiftReg right and increments BitCnt.
  - Last bit (BitCnt=bitlen-1): WordDone=1 in the same cycle.
    - If IdleGap=0 and HoldFull, load the next word immediately, so SerDataEn stays high continuously.
    - If IdleGap=0 and the holding register is empty, go to IDLE.
    - If IdleGap>0, go to GAP.
  - GAP: SerDataEn=0 for exactly IdleGap cycles, counted by GapCnt. Then go to SHIFT if HoldFull (loading as in IDLE), else to IDLE.
- Latency: a word accepted on edge t has its bit0 visible after edge t+1, provided the engine is idle. Its last bit is visible after edge t+bitlen.
- Throughput: with IdleGap=0, SerDataEn stays high continuously as long as the source refills the holding register before each word ends. The holding register frees one cycle after a transfer, leaving bitlen-1 cycles of slack.
- All outputs are registered. SerDataOut is forced to 0 in IDLE and GAP.
- Reset mid-word: the partial word and the held word are discarded, with no further SerDataEn. The downstream receiver sees a truncated word; that is acceptable.
- Counter widths: BitCnt uses $clog2(bitlen) bits and wraps to 0 after bitlen-1. GapCnt is 4 bits.

Decomposition:
- Package par2ser_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, GAP} par2ser_state_t.
  - Localparam functions for BitCnt width.
  - Maximum IdleGap constant (15).
- One sub-module is natural: par2ser_hold, the one-entry valid/ready buffer (HoldReg, HoldFull, Ready). It is reusable by future transmitters.

Test Plan:
- Reset: hold Rst=1 for 2 cycles with Valid=1 -> SerDataEn=0, SerDataOut=0, Ready=1, Busy=0, WordDone=0, and no word accepted.
- Single word 8'h2b, IdleGap=0 -> SerDataEn high for 8 cycles starting the cycle after the accept edge, with bits 1,1,0,1,0,1,0,0. WordDone pulses on the 8th bit, then SerDataEn=0 and Busy=0.
- Back-to-back 8'h2b then 8'hA5, IdleGap=0 -> 16 continuous SerDataEn cycles; second word sends 1,0,1,0,0,1,0,1; WordDone pulses twice, 8 cycles apart.
- Same pair with IdleGap=2 -> exactly 2 cycles with SerDataEn=0 and SerDataOut=0 between the words.
- Valid held high continuously with words 8'h01, 8'h80, 8'hFF -> Ready deasserts while the holding register is full. Loopback into ser2par (RstB=!Rst) yields ParDataOut 8'h01, 8'h80, 8'hFF in order, with none lost or duplicated.
- Rst pulsed for 1 cycle after the 3rd bit of 8'hA5 -> SerDataEn=0 on the next cycle, Ready=1, held word discarded. A following 8'h3c is then transmitted completely and correctly.
